// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the sram_ctrl async SRAM bridge.
// Optional feature macro used by sram_ctrl: SRAM_CTRL_POSTED_WR_EN.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_STROBE  = 2'd2,
        ST_RECOVER = 2'd3
    } state_e;

    localparam int WAIT_CYCLES_DEF = 2;
    localparam int CNT_W           = 4;

    // Strobe counter load value: the counter runs W-1 down to 0, one STROBE cycle per count.
    function automatic logic [CNT_W-1:0] strobe_load(input int wait_cycles);
        return CNT_W'(wait_cycles - 1);
    endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// On-chip request bus between a requester (master) and sram_ctrl (slave).
// Handshake: a request transfers on a rising clk edge where req && ready; ready is a registered
//   idle flag with no path from req. ack pulses for exactly one cycle per completed request.
//   rdata is valid from the read ack cycle until the next read ack.
interface sram_ctrl_if
    import sram_ctrl_pkg::*;
#(
    parameter int AW = 20,
    parameter int DW = 8
) ();

    logic          req;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ready;
    logic          ack;
    logic [DW-1:0] rdata;
    state_e        dbg_state;

    modport master (
        output req, wr, addr, wdata,
        input  ready, ack, rdata, dbg_state
    );

    modport slave (
        input  req, wr, addr, wdata,
        output ready, ack, rdata, dbg_state
    );

endinterface

// File: rtl/sram_dbus_io.sv
// Tristate SRAM data pad with registered drive enable and output data.
// Reset releases the pad asynchronously.
module sram_dbus_io #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          oe,
    input  logic [DW-1:0] dout,
    output logic [DW-1:0] din,
    inout  wire  [DW-1:0] pad
);

    logic          oe_q;
    logic [DW-1:0] dout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oe_q   <= 1'b0;
            dout_q <= '0;
        end else begin
            oe_q   <= oe;
            dout_q <= dout;
        end
    end

    assign pad = oe_q ? dout_q : {DW{1'bz}};
    assign din = pad;

endmodule

// File: rtl/sram_ctrl.sv
// Synchronous bus to async SRAM bridge: IDLE->SETUP->STROBE->RECOVER with every SRAM pin from a flop.
// Define SRAM_CTRL_POSTED_WR_EN to acknowledge writes in the SETUP cycle instead of at RECOVER.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int AW          = 20,
    parameter int DW          = 8,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    sram_ctrl_if.slave    bus,
    output logic [AW-1:0] sram_a,
    inout  wire  [DW-1:0] sram_d,
    output logic          sram_ce_n,
    output logic          sram_oe_n,
    output logic          sram_we_n
);

    state_e           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             wr_q,      wr_d;
    logic [AW-1:0]    sram_a_q,  sram_a_d;
    logic [DW-1:0]    wdata_q,   wdata_d;
    logic             ce_n_q,    ce_n_d;
    logic             oe_n_q,    oe_n_d;
    logic             we_n_q,    we_n_d;
    logic             ack_q,     ack_d;
    logic             ready_q,   ready_d;
    logic [DW-1:0]    rdata_q,   rdata_d;
    logic             drive_d;
    logic [DW-1:0]    din;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        sram_a_d = sram_a_q;
        wdata_d  = wdata_q;
        ce_n_d   = ce_n_q;
        oe_n_d   = oe_n_q;
        we_n_d   = we_n_q;
        ack_d    = 1'b0;
        ready_d  = ready_q;
        rdata_d  = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.req && ready_q) begin
                    state_d  = ST_SETUP;
                    wr_d     = bus.wr;
                    sram_a_d = bus.addr;
                    wdata_d  = bus.wdata;
                    ce_n_d   = 1'b0;
                    ready_d  = 1'b0;
`ifdef SRAM_CTRL_POSTED_WR_EN
                    ack_d    = bus.wr;
`else
                    ack_d    = 1'b0;
`endif
                end
            end
            ST_SETUP: begin
                state_d = ST_STROBE;
                cnt_d   = strobe_load(WAIT_CYCLES);
                if (wr_q) we_n_d = 1'b0;
                else      oe_n_d = 1'b0;
            end
            ST_STROBE: begin
                if (cnt_q == '0) begin
                    // Read data is captured on the same edge that lifts oe_n.
                    state_d = ST_RECOVER;
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    we_n_d  = 1'b1;
                    if (!wr_q) rdata_d = din;
`ifdef SRAM_CTRL_POSTED_WR_EN
                    ack_d   = !wr_q;
`else
                    ack_d   = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RECOVER: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                ce_n_d  = 1'b1;
                oe_n_d  = 1'b1;
                we_n_d  = 1'b1;
                ready_d = 1'b1;
            end
        endcase

        // Write data stays on the pad from SETUP through RECOVER for hold time.
        drive_d = wr_d && (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            wr_q     <= 1'b0;
            sram_a_q <= '0;
            wdata_q  <= '0;
            ce_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
            ack_q    <= 1'b0;
            ready_q  <= 1'b1;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            sram_a_q <= sram_a_d;
            wdata_q  <= wdata_d;
            ce_n_q   <= ce_n_d;
            oe_n_q   <= oe_n_d;
            we_n_q   <= we_n_d;
            ack_q    <= ack_d;
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
        end
    end

    sram_dbus_io #(
        .DW (DW)
    ) u_dbus (
        .clk   (clk),
        .rst_n (rst_n),
        .oe    (drive_d),
        .dout  (wdata_d),
        .din   (din),
        .pad   (sram_d)
    );

    assign sram_a        = sram_a_q;
    assign sram_ce_n     = ce_n_q;
    assign sram_oe_n     = oe_n_q;
    assign sram_we_n     = we_n_q;
    assign bus.ready     = ready_q;
    assign bus.ack       = ack_q;
    assign bus.rdata     = rdata_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: zero-initialised 1Mx8 async SRAM model plus a per-cycle timing reference.
// Honours SRAM_CTRL_POSTED_WR_EN for the expected write-ack cycle.
module tb_sram_ctrl;
  import sram_ctrl_pkg::*;

  localparam int AW = 20;
  localparam int DW = 8;
  localparam int W  = 2;
`ifdef SRAM_CTRL_POSTED_WR_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_ctrl_if #(.AW(AW), .DW(DW)) bus ();
  logic [AW-1:0] sram_a;
  wire  [DW-1:0] sram_d;
  logic ce_n, oe_n, we_n;

  sram_ctrl #(.AW(AW), .DW(DW), .WAIT_CYCLES(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .sram_a    (sram_a),
    .sram_d    (sram_d),
    .sram_ce_n (ce_n),
    .sram_oe_n (oe_n),
    .sram_we_n (we_n)
  );

  // ---------------- async SRAM model ----------------
  logic [7:0] mem [0:(1<<AW)-1];
  assign sram_d = (!ce_n && !oe_n) ? mem[sram_a] : {DW{1'bz}};

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
    forever begin
      @(negedge clk);
      if (!ce_n && !we_n) mem[sram_a] = sram_d;
    end
  end

  // ---------------- counters / checker ----------------
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] exp_q[$];
  logic [7:0]    ref_mem [int];
  int            cyc = 0;
  bit            busy = 1'b0;
  int            acc_cyc = 0;
  bit            t_wr;
  logic [AW-1:0] t_addr;
  logic [7:0]    t_wdata;
  logic [7:0]    exp_rdata = 8'h00;
  int            acc_count = 0;
  int            acc_hist[$];
  int            last_ack_obs = -1;

  function automatic logic [7:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 8'h00;
  endfunction

  always @(negedge clk) begin
    int  rel;
    int  ack_rel;
    bit  e_ce_n, e_oe_n, e_we_n, e_drive, e_ack;
    cyc++;
    if (bus.ack) last_ack_obs = cyc;
    if (!rst_n) begin
      busy = 1'b0;
      exp_rdata = 8'h00;
      exp_q.delete();
      chk("rst_ready", bus.ready, 1);
      chk("rst_ack",   bus.ack, 0);
      chk("rst_ce_n",  ce_n, 1);
      chk("rst_oe_n",  oe_n, 1);
      chk("rst_we_n",  we_n, 1);
      chk("rst_drive", dut.u_dbus.oe_q, 0);
      chk("rst_rdata", bus.rdata, 0);
    end else begin
      rel = cyc - acc_cyc;
      if (busy && rel > W + 2) busy = 1'b0;
      e_ce_n  = !(busy && rel >= 1 && rel <= W + 1);
      e_oe_n  = !(busy && !t_wr && rel >= 2 && rel <= W + 1);
      e_we_n  = !(busy &&  t_wr && rel >= 2 && rel <= W + 1);
      e_drive = busy && t_wr && rel >= 1;
      ack_rel = (t_wr && POSTED) ? 1 : W + 2;
      e_ack   = busy && rel == ack_rel;
      if (busy && !t_wr && rel == W + 2) begin
        if (exp_q.size() > 0) exp_rdata = exp_q.pop_front();
      end
      if (busy && t_wr && rel == W + 2) ref_mem[int'(t_addr)] = t_wdata;

      chk("ready", bus.ready, !busy);
      chk("ack",   bus.ack, e_ack);
      chk("ce_n",  ce_n, e_ce_n);
      chk("oe_n",  oe_n, e_oe_n);
      chk("we_n",  we_n, e_we_n);
      chk("drive", dut.u_dbus.oe_q, e_drive);
      chk("rdata", bus.rdata, exp_rdata);
      if (!e_ce_n) chk("sram_a", sram_a, t_addr);
      if (e_drive) chk("sram_d_wr", sram_d, t_wdata);
      chk("oe_we_overlap", !oe_n && !we_n, 0);
      chk("drive_while_oe", dut.u_dbus.oe_q && !oe_n, 0);

      if (!busy && bus.req) begin
        busy = 1'b1;
        acc_cyc = cyc;
        t_wr = bus.wr;
        t_addr = bus.addr;
        t_wdata = bus.wdata;
        acc_count++;
        acc_hist.push_back(cyc);
        if (!bus.wr) exp_q.push_back(ref_rd(bus.addr));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_op(input bit w, input logic [AW-1:0] a, input logic [7:0] d, input bit keep);
    int start;
    int budget;
    start = acc_count;
    budget = 0;
    bus.req = 1'b1;
    bus.wr = w;
    bus.addr = a;
    bus.wdata = d;
    while (acc_count == start && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    chk("accept_timeout", 32'(acc_count != start), 1);
    if (!keep) bus.req = 1'b0;
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    while (busy && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    chk("idle_timeout", 32'(busy), 0);
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int a0;
    bus.req = 1'b0;
    bus.wr = 1'b0;
    bus.addr = '0;
    bus.wdata = '0;
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // write then read back one location
    do_op(1'b1, 20'h00123, 8'h5A, 1'b0);
    a0 = acc_hist[$];
    wait_idle();
    chk("wr_ack_latency", 32'(last_ack_obs - a0), POSTED ? 32'd1 : 32'(W + 2));
    do_op(1'b0, 20'h00123, 8'h00, 1'b0);
    a0 = acc_hist[$];
    wait_idle();
    chk("rd_ack_latency", 32'(last_ack_obs - a0), 32'd4);
    chk("rd_5a", bus.rdata, 8'h5A);
    chk("mem_123", mem[20'h00123], 8'h5A);

    // address extremes, no aliasing
    do_op(1'b1, 20'hFFFFF, 8'hA5, 1'b0);
    wait_idle();
    do_op(1'b1, 20'h00000, 8'h3C, 1'b0);
    wait_idle();
    do_op(1'b0, 20'hFFFFF, 8'h00, 1'b0);
    wait_idle();
    chk("rd_top", bus.rdata, 8'hA5);
    do_op(1'b0, 20'h00000, 8'h00, 1'b0);
    wait_idle();
    chk("rd_bottom", bus.rdata, 8'h3C);

    // back-to-back with req held high
    do_op(1'b1, 20'h00200, 8'h11, 1'b1);
    do_op(1'b0, 20'h00200, 8'h00, 1'b1);
    do_op(1'b1, 20'h00201, 8'h22, 1'b1);
    do_op(1'b0, 20'h00201, 8'h00, 1'b0);
    wait_idle();
    for (int i = 1; i < 4; i++)
      chk("b2b_spacing", 32'(acc_hist[acc_hist.size()-i] - acc_hist[acc_hist.size()-i-1]), 32'd5);
    chk("b2b_rd", bus.rdata, 8'h22);

    // reset in the middle of a write strobe
    do_op(1'b1, 20'h00010, 8'hFF, 1'b0);
    @(posedge clk); #2;
    a0 = last_ack_obs;
    rst_n = 1'b0;
    #1;
    chk("midrst_we_n", we_n, 1);
    chk("midrst_ce_n", ce_n, 1);
    chk("midrst_oe_n", oe_n, 1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ready", bus.ready, 1);
    chk("midrst_no_ack", 32'(last_ack_obs), 32'(a0));

    // randomized traffic over a small address pool
    for (int n = 0; n < 60; n++) begin
      logic [AW-1:0] a;
      case ($urandom_range(0, 3))
        0: a = 20'h00123;
        1: a = 20'hFFFFF;
        2: a = AW'($urandom_range(0, 7));
        default: a = AW'($urandom_range(32, 39));
      endcase
      do_op(1'($urandom_range(0, 1)), a, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      if (!bus.req) repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    bus.req = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL global_timeout: got running expected finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
